// File: rtl/sound_sched_pkg.sv
// Shared definitions for the sound trigger scheduler.
//   state_e   : per-channel scheduling state (IDLE, WAIT, RUN, HOLD)
//   cnt_width : minimum hold-counter width able to hold a given count
package sound_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Bits needed to represent 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sound_trigger_scheduler_if.sv
// Bus between the sound-latch side and the trigger scheduler.
//   audio_clk_en : one-clk strobe at the audio sample rate
//   trig_in      : raw CPU latch trigger bits (may be asynchronous)
//   en_out       : registered enable per discrete sound circuit
//   active_count : number of currently enabled channels
//   drop_pulse   : one-clk pulse when a waiting request is withdrawn
// master drives the triggers and strobe, slave is the scheduler.
interface sound_trigger_scheduler_if #(
  parameter int NUM_SOUNDS = 4,
  parameter int MAX_ACTIVE = 2
);
  localparam int ACT_W = $clog2(MAX_ACTIVE + 1);

  logic                  audio_clk_en;
  logic [NUM_SOUNDS-1:0] trig_in;
  logic [NUM_SOUNDS-1:0] en_out;
  logic [ACT_W-1:0]      active_count;
  logic                  drop_pulse;

  modport master (
    output audio_clk_en, trig_in,
    input  en_out, active_count, drop_pulse
  );

  modport slave (
    input  audio_clk_en, trig_in,
    output en_out, active_count, drop_pulse
  );
endinterface

// File: rtl/sound_trigger_channel.sv
// One trigger channel: IDLE/WAIT/RUN/HOLD state machine, minimum-hold
// counter and the previous-req register used for retrigger detection.
// Everything advances only on clk edges where tick is high.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : audio sample strobe
//   req        : conditioned active-high request
//   grant      : slot granted this tick (only meaningful in IDLE/WAIT)
//   preempt    : this channel is the preemption victim this tick
//   state      : current state
//   occupied   : registered "channel holds a slot" (RUN or HOLD)
module sound_trigger_channel
  import sound_sched_pkg::*;
#(
  parameter int MIN_HOLD_SAMPLES = 2400,
  parameter int CNT_W            = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   tick,
  input  logic   req,
  input  logic   grant,
  input  logic   preempt,
  output state_e state,
  output logic   occupied
);
  // Never narrower than what the hold length needs.
  localparam int HOLD_W = (CNT_W > cnt_width(MIN_HOLD_SAMPLES)) ?
                          CNT_W : cnt_width(MIN_HOLD_SAMPLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_SAMPLES);
  localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);

  state_e             state_reg, state_next;
  logic [HOLD_W-1:0]  cnt_reg, cnt_next;
  logic               req_prev_reg;
  logic               occupied_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      req_prev_reg <= 1'b0;
      occupied_reg <= 1'b0;
    end else if (tick) begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_prev_reg <= req;
      occupied_reg <= (state_next == RUN) || (state_next == HOLD);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (preempt) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (grant) begin
              state_next = RUN;
              cnt_next   = CNT_ONE;
            end else begin
              state_next = WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state_next = IDLE;
          end else if (grant) begin
            state_next = RUN;
            cnt_next   = CNT_ONE;
          end
        end
        RUN: begin
          if (req) begin
            if (cnt_reg < HOLD_MAX) cnt_next = cnt_reg + CNT_ONE;
          end else if (cnt_reg >= HOLD_MAX) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            state_next = HOLD;
            cnt_next   = cnt_reg + CNT_ONE;
          end
        end
        HOLD: begin
          // Only a fresh rising edge restarts; a level held high does not.
          if (req && !req_prev_reg) begin
            state_next = RUN;
            cnt_next   = CNT_ONE;
          end else if (cnt_reg >= HOLD_MAX) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign state    = state_reg;
  assign occupied = occupied_reg;

endmodule

// File: rtl/sound_trigger_scheduler.sv
// Sound trigger scheduler: synchronises and polarity-normalises the CPU
// sound-latch bits, enforces a minimum enable time per sound and limits
// the number of simultaneously enabled circuits by fixed priority
// (index 0 highest).
// Ports:
//   clk    : system clock
//   I_RSTn : asynchronous active-low reset
//   bus    : sound_trigger_scheduler_if.slave (audio_clk_en, trig_in,
//            en_out, active_count, drop_pulse)
// Optional build macro SOUND_SCHED_PREEMPT_EN: when no slot is free, the
// highest-priority candidate may take the slot of the highest-index HOLD
// channel of lower priority (one preemption per tick).
module sound_trigger_scheduler
  import sound_sched_pkg::*;
#(
  parameter int                    NUM_SOUNDS       = 4,
  parameter int                    MAX_ACTIVE       = 2,
  parameter int                    MIN_HOLD_SAMPLES = 2400,
  parameter logic [NUM_SOUNDS-1:0] ACTIVE_LOW_MASK  = '0,
  parameter int                    CNT_W            = 16
) (
  input logic                      clk,
  input logic                      I_RSTn,
  sound_trigger_scheduler_if.slave bus
);
  localparam int ACT_W = $clog2(MAX_ACTIVE + 1);

  logic [NUM_SOUNDS-1:0] sync1_reg, sync2_reg;
  logic [NUM_SOUNDS-1:0] req;
  logic [NUM_SOUNDS-1:0] cand;
  logic [NUM_SOUNDS-1:0] withdraw;
  logic [NUM_SOUNDS-1:0] grant_base;
  logic [NUM_SOUNDS-1:0] grant;
  logic [NUM_SOUNDS-1:0] preempt;
  logic [NUM_SOUNDS-1:0] occupied;
  state_e                chan_state [NUM_SOUNDS];
  logic                  drop_reg;
  logic [ACT_W-1:0]      act_count;
  int                    free_num;

  // Two-flop synchroniser; resets to the inactive input level.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      sync1_reg <= ACTIVE_LOW_MASK;
      sync2_reg <= ACTIVE_LOW_MASK;
    end else begin
      sync1_reg <= bus.trig_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign req = sync2_reg ^ ACTIVE_LOW_MASK;

  for (genvar gi = 0; gi < NUM_SOUNDS; gi++) begin : g_chan
    // A WAIT channel whose request has gone is leaving this tick, so it
    // must not soak up a slot that a lower-priority requester could use.
    assign cand[gi]     = req[gi] && ((chan_state[gi] == IDLE) || (chan_state[gi] == WAIT));
    assign withdraw[gi] = (chan_state[gi] == WAIT) && !req[gi];

    sound_trigger_channel #(
      .MIN_HOLD_SAMPLES (MIN_HOLD_SAMPLES),
      .CNT_W            (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (I_RSTn),
      .tick     (bus.audio_clk_en),
      .req      (req[gi]),
      .grant    (grant[gi]),
      .preempt  (preempt[gi]),
      .state    (chan_state[gi]),
      .occupied (occupied[gi])
    );
  end

  // Fixed-priority grant from pre-tick occupancy: slots released on this
  // tick only become free on the following one.
  always_comb begin
    int occ_num;
    int given;
    occ_num = 0;
    for (int i = 0; i < NUM_SOUNDS; i++) begin
      if (occupied[i]) occ_num++;
    end
    free_num   = MAX_ACTIVE - occ_num;
    given      = 0;
    grant_base = '0;
    for (int i = 0; i < NUM_SOUNDS; i++) begin
      if (cand[i] && (given < free_num)) begin
        grant_base[i] = 1'b1;
        given++;
      end
    end
  end

`ifdef SOUND_SCHED_PREEMPT_EN
  logic [NUM_SOUNDS-1:0] grant_pre;

  always_comb begin
    int first_cand;
    int victim;
    first_cand = NUM_SOUNDS;
    victim     = NUM_SOUNDS;
    grant_pre  = '0;
    preempt    = '0;
    for (int i = 0; i < NUM_SOUNDS; i++) begin
      if (cand[i] && (first_cand == NUM_SOUNDS)) first_cand = i;
    end
    // Last match wins: the lowest-priority HOLD channel below the candidate.
    for (int i = 0; i < NUM_SOUNDS; i++) begin
      if ((chan_state[i] == HOLD) && (i > first_cand)) victim = i;
    end
    if ((free_num == 0) && (victim < NUM_SOUNDS)) begin
      for (int i = 0; i < NUM_SOUNDS; i++) begin
        if (i == first_cand) grant_pre[i] = 1'b1;
        if (i == victim)     preempt[i]   = 1'b1;
      end
    end
  end

  assign grant = grant_base | grant_pre;
`else
  assign grant   = grant_base;
  assign preempt = '0;
`endif

  // Withdrawal is registered so the pulse lasts exactly one clk.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      drop_reg <= 1'b0;
    end else begin
      drop_reg <= bus.audio_clk_en && (|withdraw);
    end
  end

  // Popcount of the registered enables, so it always matches en_out.
  always_comb begin
    act_count = '0;
    for (int i = 0; i < NUM_SOUNDS; i++) begin
      act_count = act_count + ACT_W'(occupied[i]);
    end
  end

  assign bus.en_out       = occupied;
  assign bus.active_count = act_count;
  assign bus.drop_pulse   = drop_reg;

endmodule

// File: tb/tb_sound_trigger_scheduler.sv
// Directed bench for sound_trigger_scheduler: MIN_HOLD_SAMPLES=4,
// MAX_ACTIVE=2, NUM_SOUNDS=4, audio_clk_en every 8 clk.
module tb_sound_trigger_scheduler;

  logic clk = 1'b0;
  logic I_RSTn;

  sound_trigger_scheduler_if #(.NUM_SOUNDS(4), .MAX_ACTIVE(2)) bus ();

  sound_trigger_scheduler #(
    .NUM_SOUNDS       (4),
    .MAX_ACTIVE       (2),
    .MIN_HOLD_SAMPLES (4),
    .ACTIVE_LOW_MASK  (4'b0000),
    .CNT_W            (16)
  ) dut (
    .clk    (clk),
    .I_RSTn (I_RSTn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic       drop;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] last_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive trig right after a tick, expect the post-tick outputs of the
  // next tick. Also confirms outputs are held between ticks and that the
  // previous drop pulse lasted a single clk.
  task automatic step(input logic [3:0] trig, input logic [3:0] exp_en,
                      input logic exp_drop, input string tag);
    exp_t e;
    exp_t got;
    bus.trig_in = trig;
    e.en   = exp_en;
    e.drop = exp_drop;
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    check({tag, "/held"}, 32'(bus.en_out), 32'(last_en));
    check({tag, "/drop_width"}, 32'(bus.drop_pulse), 32'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.audio_clk_en = 1'b1;
    @(posedge clk); #1;
    bus.audio_clk_en = 1'b0;
    got = sb_q.pop_front();
    check({got.tag, "/en_out"}, 32'(bus.en_out), 32'(got.en));
    check({got.tag, "/active_count"}, 32'(bus.active_count), 32'($countones(got.en)));
    check({got.tag, "/drop_pulse"}, 32'(bus.drop_pulse), 32'(got.drop));
    $display("tick %-22s trig=%b en_out=%b active=%0d drop=%b", got.tag, trig,
             bus.en_out, bus.active_count, bus.drop_pulse);
    last_en = got.en;
  endtask

  initial begin
    I_RSTn           = 1'b0;
    bus.trig_in      = 4'b0000;
    bus.audio_clk_en = 1'b0;
    last_en          = 4'b0000;
    repeat (3) @(posedge clk); #1;
    check("reset/en_out", 32'(bus.en_out), 32'd0);
    check("reset/active_count", 32'(bus.active_count), 32'd0);
    check("reset/drop_pulse", 32'(bus.drop_pulse), 32'd0);
    @(negedge clk);
    I_RSTn = 1'b1;
    @(posedge clk); #1;

    // Short pulse: one tick of request gives exactly four enabled ticks.
    step(4'b0001, 4'b0001, 1'b0, "short_run");
    step(4'b0000, 4'b0001, 1'b0, "short_hold2");
    step(4'b0000, 4'b0001, 1'b0, "short_hold3");
    step(4'b0000, 4'b0001, 1'b0, "short_hold4");
    step(4'b0000, 4'b0000, 1'b0, "short_off");

    // Long pulse: ten ticks high, off on the first tick with req=0.
    for (int i = 0; i < 10; i++) step(4'b0010, 4'b0010, 1'b0, "long_run");
    step(4'b0000, 4'b0000, 1'b0, "long_off");

    // Contention: two slots, channels 2 and 3 wait.
    step(4'b1111, 4'b0011, 1'b0, "cont_grant01");
    step(4'b1100, 4'b0011, 1'b0, "cont_hold2");
    step(4'b1100, 4'b0011, 1'b0, "cont_hold3");
    step(4'b1100, 4'b0011, 1'b0, "cont_hold4");
    step(4'b1100, 4'b0000, 1'b0, "cont_freed");
    step(4'b1100, 4'b1100, 1'b0, "cont_grant23");
    step(4'b0000, 4'b1100, 1'b0, "cont23_hold2");
    step(4'b0000, 4'b1100, 1'b0, "cont23_hold3");
    step(4'b0000, 4'b1100, 1'b0, "cont23_hold4");
    step(4'b0000, 4'b0000, 1'b0, "cont23_off");

    // Withdraw: channel 3 waits, then drops its request.
    step(4'b0011, 4'b0011, 1'b0, "wd_grant01");
    step(4'b1011, 4'b0011, 1'b0, "wd_ch3_wait");
    step(4'b0011, 4'b0011, 1'b1, "wd_ch3_drop");
    step(4'b0000, 4'b0011, 1'b0, "wd_hold4");
    step(4'b0000, 4'b0000, 1'b0, "wd_off");

    // Retrigger during HOLD restarts the hold count.
    step(4'b0001, 4'b0001, 1'b0, "rt_run");
    step(4'b0000, 4'b0001, 1'b0, "rt_hold2");
    step(4'b0000, 4'b0001, 1'b0, "rt_hold3");
    step(4'b0001, 4'b0001, 1'b0, "rt_retrig");
    step(4'b0000, 4'b0001, 1'b0, "rt_hold2b");
    step(4'b0000, 4'b0001, 1'b0, "rt_hold3b");
    step(4'b0000, 4'b0001, 1'b0, "rt_hold4b");
    step(4'b0000, 4'b0000, 1'b0, "rt_off");

    // Asynchronous reset in the middle of a hold.
    step(4'b0001, 4'b0001, 1'b0, "rst_run");
    step(4'b0000, 4'b0001, 1'b0, "rst_hold2");
    @(posedge clk); #2;
    check("rst_pre/en_out", 32'(bus.en_out), 32'h1);
    I_RSTn = 1'b0;
    #1;
    check("rst_async/en_out", 32'(bus.en_out), 32'd0);
    check("rst_async/active_count", 32'(bus.active_count), 32'd0);
    $display("async reset mid-hold en_out=%b active=%0d", bus.en_out, bus.active_count);
    repeat (2) @(posedge clk);
    @(negedge clk);
    I_RSTn  = 1'b1;
    last_en = 4'b0000;
    @(posedge clk); #1;
    step(4'b0000, 4'b0000, 1'b0, "post_reset_idle");

    // Channels 2 and 3 in HOLD when channel 0 arrives.
    step(4'b1100, 4'b1100, 1'b0, "pre_run23");
    step(4'b0000, 4'b1100, 1'b0, "pre_hold23");
`ifdef SOUND_SCHED_PREEMPT_EN
    step(4'b0001, 4'b0101, 1'b0, "preempt_ch3");
    step(4'b0001, 4'b0101, 1'b0, "preempt_ch2_hold4");
    step(4'b0001, 4'b0001, 1'b0, "preempt_ch2_off");
    step(4'b0001, 4'b0001, 1'b0, "preempt_ch0_run");
`else
    step(4'b0001, 4'b1100, 1'b0, "nopre_ch0_wait");
    step(4'b0001, 4'b1100, 1'b0, "nopre_hold4");
    step(4'b0001, 4'b0000, 1'b0, "nopre_freed");
    step(4'b0001, 4'b0001, 1'b0, "nopre_ch0_grant");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
